// File: rtl/my_fifo_bulk_reader.sv
// my_fifo_bulk_reader: bulk FIFO-to-stream reader with 2-entry skid buffer; define MY_FIFO_BULK_READER_TLAST_EN for m_tlast
module my_fifo_bulk_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int BULK_OF_DATA = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_r_ready,
  output logic                  fifo_r_enable,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_error_empty,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [15:0]           bulk_count,
  output logic                  err_underrun
);
  localparam int CW = $clog2(BULK_OF_DATA) + 1;
  localparam logic [CW-1:0] BULK = CW'(BULK_OF_DATA);
  localparam logic [CW-1:0] LAST = CW'(BULK_OF_DATA - 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state;
  logic [CW-1:0] issued, sent;
  logic [1:0] occ, occ_n;
  logic rd_pend, xfer;
  logic [DATA_WIDTH-1:0] b1;
  assign m_tvalid = occ != 2'd0;
  assign xfer = m_tvalid && m_tready;
  // occupancy after this cycle's capture and transfer, which also bounds buffer plus in-flight reads
  assign occ_n = occ + {1'b0, rd_pend} - {1'b0, xfer};
  assign fifo_r_enable = state == READ && issued < BULK && occ_n < 2'd2;
`ifdef MY_FIFO_BULK_READER_TLAST_EN
  assign m_tlast = m_tvalid && sent == LAST;
`else
  assign m_tlast = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      issued       <= '0;
      sent         <= '0;
      occ          <= '0;
      rd_pend      <= 1'b0;
      m_tdata      <= '0;
      b1           <= '0;
      bulk_count   <= '0;
      err_underrun <= 1'b0;
    end else begin
      rd_pend <= fifo_r_enable;
      occ     <= occ_n;
      if (rd_pend && (occ == 2'd0 || (occ == 2'd1 && xfer))) m_tdata <= fifo_rdata;
      else if (xfer && occ == 2'd2) m_tdata <= b1;
      if (rd_pend && occ_n == 2'd2) b1 <= fifo_rdata;
      if (rd_pend && fifo_error_empty) err_underrun <= 1'b1;
      if (fifo_r_enable) issued <= issued + CW'(1);
      if (xfer) sent <= sent + CW'(1);
      if (state == IDLE && fifo_r_ready) begin
        state  <= READ;
        issued <= '0;
        sent   <= '0;
      end else if (state == READ && fifo_r_enable && issued == LAST) state <= DRAIN;
      else if (state == DRAIN && xfer && sent == LAST) begin
        state      <= IDLE;
        bulk_count <= bulk_count + 16'd1;
      end
    end
endmodule
